// File: rtl/hamming_tx_arb.sv
// hamming_tx_arb: two-requester round-robin arbiter feeding a Hamming(7,4)
// serialiser. Each grant captures one nibble, encodes it and shifts the code
// word out LSB (code[1]) first, one bit per cycle.
// Optional feature: define HAMMING_TX_SECDED_EN to append an even overall
// parity bit as bit 8 of every frame.
module hamming_tx_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [3:0] data_a,
    output logic       gnt_a,
    input  logic       req_b,
    input  logic [3:0] data_b,
    output logic       gnt_b,
    output logic       tx_bit,
    output logic       tx_valid,
    output logic       tx_first,
    output logic       tx_last,
    output logic       tx_src,
    output logic       busy
);

`ifdef HAMMING_TX_SECDED_EN
    localparam int unsigned NBITS = 8;
`else
    localparam int unsigned NBITS = 7;
`endif
    localparam logic [2:0] LAST_IDX = 3'(NBITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [2:0]       cnt;
    logic [NBITS-1:0] sr;
    logic             last_b;
    logic             src;
    logic             eligible;
    logic             win_a, win_b, grant;
    logic [3:0]       win_data;
    logic [6:0]       code;
    logic [NBITS-1:0] frame;

    // Arbitration: round-robin on a tie, grants only when the shifter can accept
    always_comb begin
        eligible = rst_n && ((state == IDLE) || tx_last);
        win_a    = req_a && (!req_b || last_b);
        win_b    = req_b && !win_a;
        gnt_a    = eligible && win_a;
        gnt_b    = eligible && win_b;
        grant    = gnt_a || gnt_b;
        win_data = win_a ? data_a : data_b;
    end

    // Hamming encode of the winning nibble; code[0] is transmitted first
    always_comb begin
        code[6] = win_data[3];
        code[5] = win_data[2];
        code[4] = win_data[1];
        code[3] = win_data[1] ^ win_data[2] ^ win_data[3];
        code[2] = win_data[0];
        code[1] = win_data[0] ^ win_data[2] ^ win_data[3];
        code[0] = win_data[0] ^ win_data[1] ^ win_data[3];
`ifdef HAMMING_TX_SECDED_EN
        frame   = {^code, code};
`else
        frame   = code;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: leave SHIFT after the last bit unless a new frame is granted
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = SHIFT;
            SHIFT:   if (tx_last && !grant) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from state and bit index
    always_comb begin
        busy     = (state == SHIFT);
        tx_valid = busy;
        tx_first = busy && (cnt == 3'd0);
        tx_last  = busy && (cnt == LAST_IDX);
        tx_bit   = busy & sr[0];
        tx_src   = src;
    end

    // Datapath: load on grant, otherwise shift and count through the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            cnt    <= '0;
            src    <= 1'b0;
            last_b <= 1'b1;
        end else if (grant) begin
            sr     <= frame;
            cnt    <= '0;
            src    <= win_b;
            last_b <= win_b;
        end else if (state == SHIFT) begin
            if (tx_last) begin
                sr  <= '0;
                cnt <= '0;
            end else begin
                sr  <= sr >> 1;
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_tx_arb.sv
// tb_hamming_tx_arb: randomized bench for hamming_tx_arb against a queue-based
// model of the expected serial stream and grant decisions.
module tb_hamming_tx_arb;

`ifdef HAMMING_TX_SECDED_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif

    logic       clk = 1'b0;
    logic       rst_n, req_a, req_b;
    logic [3:0] data_a, data_b;
    logic       gnt_a, gnt_b, tx_bit, tx_valid, tx_first, tx_last, tx_src, busy;

    hamming_tx_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
        .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_first(tx_first),
        .tx_last(tx_last), .tx_src(tx_src), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: queue of bits still to be sent in the current frame
    bit         q[$];
    int         idx;
    bit         m_src, m_lastb;
    bit         ga, gb;
    logic [7:0] exp_v, act_v;
    int         tests = 0, fails = 0;

    // Frame bits in transmit order: p1,p2,d3,p4,d5,d6,d7[,overall parity]
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic d3, d5, d6, d7;
        logic [7:0] b;
        d3 = d[0]; d5 = d[1]; d6 = d[2]; d7 = d[3];
        b[0] = d3 ^ d5 ^ d7;
        b[1] = d3 ^ d6 ^ d7;
        b[2] = d3;
        b[3] = d5 ^ d6 ^ d7;
        b[4] = d5;
        b[5] = d6;
        b[6] = d7;
        b[7] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        idx     = 0;
        m_src   = 1'b0;
        m_lastb = 1'b1;
    endtask

    // Expected outputs for the current cycle, plus the matching DUT vector
    task automatic eval();
        bit elig, v;
        elig  = (q.size() <= 1);
        v     = (q.size() > 0);
        ga    = rst_n && elig && req_a && (!req_b || m_lastb);
        gb    = rst_n && elig && req_b && (!req_a || !m_lastb);
        exp_v = {ga, gb, v, v ? q[0] : 1'b0, v && idx == 0, q.size() == 1, v, v && m_src};
        act_v = {gnt_a, gnt_b, tx_valid, tx_bit, tx_first, tx_last, busy, tx_valid & tx_src};
    endtask

    // Model clock edge: consume one bit, load a new frame on grant
    task automatic model_edge();
        logic [7:0] c;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (q.size() > 0) begin
            void'(q.pop_front());
            idx++;
        end
        if (ga || gb) begin
            c = enc(ga ? data_a : data_b);
            q.delete();
            for (int i = 0; i < NB; i++) q.push_back(c[i]);
            idx     = 0;
            m_src   = gb;
            m_lastb = gb;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
        data_a = 4'b1011; data_b = 4'b0110;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            eval();
            tests++;
            if ({act_v, tx_src} !== 9'd0 || act_v !== exp_v) begin
                fails++;
                $display("FAIL reset cyc %0d: got %b src %b, want 0", c, act_v, tx_src);
            end
            model_edge();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tie();
        int ga_cyc = -1, gb_cyc = -1, vcnt = 0;
        bit src_last = 1'b0;
        for (int c = 0; c < 2 * NB + 4; c++) begin
            #1;
            eval();
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL tie cyc %0d: got %b want %b", c, act_v, exp_v);
            end
            if (gnt_a && ga_cyc < 0) ga_cyc = c;
            if (gnt_b && gb_cyc < 0) gb_cyc = c;
            if (tx_valid) begin vcnt++; src_last = tx_src; end
            model_edge();
            @(negedge clk);
            if (ga) req_a = 1'b0;
            if (gb) req_b = 1'b0;
        end
        tests++;
        if (ga_cyc != 0 || gb_cyc != NB || vcnt != 2 * NB || src_last !== 1'b1) begin
            fails++;
            $display("FAIL tie_order: gnt_a@%0d gnt_b@%0d valid %0d src %b, want 0 %0d %0d 1",
                     ga_cyc, gb_cyc, vcnt, src_last, NB, 2 * NB);
        end
    endtask

    task automatic test_single();
        logic [7:0] obs = '0;
        logic [7:0] want = 8'b0101_0101;
        int nv = 0, ng = 0;
        req_a = 1'b1; data_a = 4'b1011; req_b = 1'b0;
        for (int c = 0; c < NB + 4; c++) begin
            #1;
            eval();
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL single cyc %0d: got %b want %b", c, act_v, exp_v);
            end
            if (gnt_a) ng++;
            if (tx_valid && nv < 8) begin obs[nv] = tx_bit; nv++; end
            model_edge();
            @(negedge clk);
            if (ga) req_a = 1'b0;
        end
        tests++;
        if (ng != 1 || nv != NB || obs !== (want & 8'((1 << NB) - 1))) begin
            fails++;
            $display("FAIL single_seq: bits %b n %0d gnt %0d, want %b n %0d gnt 1",
                     obs, nv, ng, want & 8'((1 << NB) - 1), NB);
        end
    endtask

    task automatic test_encoding();
        logic [3:0] din[2]  = '{4'b0001, 4'b0000};
        logic [7:0] wseq[2] = '{8'b1000_0111, 8'b0000_0000};
        for (int t = 0; t < 2; t++) begin
            logic [7:0] obs = '0;
            int nv = 0;
            req_b = 1'b1; data_b = din[t];
            for (int c = 0; c < NB + 3; c++) begin
                #1;
                eval();
                tests++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL encode%0d cyc %0d: got %b want %b", t, c, act_v, exp_v);
                end
                if (tx_valid && nv < 8) begin obs[nv] = tx_bit; nv++; end
                model_edge();
                @(negedge clk);
                if (gb) req_b = 1'b0;
            end
            tests++;
            if (nv != NB || obs !== (wseq[t] & 8'((1 << NB) - 1))) begin
                fails++;
                $display("FAIL encode%0d_seq: bits %b n %0d, want %b", t, obs, nv,
                         wseq[t] & 8'((1 << NB) - 1));
            end
        end
    endtask

    task automatic test_withdraw();
        int nb = 0;
        req_a = 1'b1; data_a = 4'($urandom); req_b = 1'b0; data_b = 4'($urandom);
        for (int c = 0; c < NB + 4; c++) begin
            #1;
            eval();
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL withdraw cyc %0d: got %b want %b", c, act_v, exp_v);
            end
            if (gnt_b) nb++;
            model_edge();
            @(negedge clk);
            if (ga) req_a = 1'b0;
            req_b = (q.size() > 0) && (idx >= 1) && (idx <= 3);
        end
        tests++;
        if (nb != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL withdraw_end: gnt_b %0d busy %b, want 0 0", nb, busy);
        end
    endtask

    task automatic test_back_to_back();
        req_a = 1'b0; req_b = 1'b0;
        for (int c = 0; c < 500; c++) begin
            #1;
            eval();
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL random cyc %0d: got %b want %b", c, act_v, exp_v);
            end
            model_edge();
            @(negedge clk);
            if (ga || !req_a) begin
                req_a  = ($urandom_range(0, 3) != 0);
                data_a = 4'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req_a = 1'b0;
            end
            if (gb || !req_b) begin
                req_b  = ($urandom_range(0, 3) != 0);
                data_b = 4'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req_b = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit hit = 1'b0;
        int nv = 0;
        req_a = 1'b0; req_b = 1'b0;
        repeat (NB + 1) @(negedge clk);
        model_reset();
        m_lastb = 1'b0;
        // align model with DUT last-served by forcing a lone B request
        req_b = 1'b1; data_b = 4'($urandom);
        for (int c = 0; c < 20 && !hit; c++) begin
            if (q.size() > 0 && idx == 3) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                eval();
                tests++;
                if ({act_v, tx_src} !== 9'd0 || act_v !== exp_v) begin
                    fails++;
                    $display("FAIL reset_mid: got %b src %b, want 0", act_v, tx_src);
                end
                hit = 1'b1;
            end else begin
                #1;
                eval();
                model_edge();
                @(negedge clk);
                if (gb) req_b = 1'b1;
            end
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL reset_mid_reach: bit 4 not reached, want reached");
        end
        @(negedge clk);
        rst_n = 1'b1; req_b = 1'b0;
        for (int c = 0; c < NB + 4; c++) begin
            #1;
            eval();
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL post_reset cyc %0d: got %b want %b", c, act_v, exp_v);
            end
            if (tx_valid) nv++;
            model_edge();
            @(negedge clk);
        end
        tests++;
        if (nv != 0) begin
            fails++;
            $display("FAIL post_reset_valid: %0d valid cycles, want 0", nv);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_encoding();
        test_withdraw();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hamming_tx_arb.md
HAMMING_TX_ARB -- requirements
Module: hamming_tx_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be as listed below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_a  in  1  requester A has a nibble to send.
REQ-005 data_a  in  4  requester A nibble, [4:1] order.
REQ-006 gnt_a  out  1  one-cycle pulse: data_a is accepted this cycle.
REQ-007 req_b  in  1  requester B has a nibble to send.
REQ-008 data_b  in  4  requester B nibble, [4:1] order.
REQ-009 gnt_b  out  1  one-cycle pulse: data_b is accepted this cycle.
REQ-010 tx_bit  out  1  serial code bit.
REQ-011 tx_valid  out  1  tx_bit is valid this cycle.
REQ-012 tx_first  out  1  tx_bit is bit 1 of a frame.
REQ-013 tx_last  out  1  tx_bit is the final bit of a frame.
REQ-014 tx_src  out  1  source of the current frame: 0 = A, 1 = B.
REQ-015 busy  out  1  a frame is being shifted (state SHIFT).

Function
REQ-016 The FSM SHALL have two states: IDLE and SHIFT.
REQ-017 Grant eligibility: a grant SHALL be issued in IDLE, or in the tx_last cycle of SHIFT, whenever req_a or req_b is high.
REQ-018 Arbitration: a single request SHALL win; if both are high, the requester not served last SHALL win (round-robin); last-served SHALL reset to B, so A wins the first tie.
REQ-019 On the grant edge: capture the winner's data; encode it internally; load the shift register; set tx_src; update last-served; enter or stay in SHIFT.
REQ-020 Encoding mapping: d7=data[4], d6=data[3], d5=data[2], d3=data[1].
REQ-021 Parity bits: p1=d3^d5^d7, p2=d3^d6^d7, p4=d5^d6^d7.
REQ-022 Code word: code[7:1] = {d7,d6,d5,p4,d3,p2,p1}.
REQ-023 Shift order: code[1] SHALL go first and code[7] last, one bit per cycle, with tx_valid=1.
REQ-024 Latency: with a grant in cycle N, bit 1 SHALL appear in N+1 and bit 7 in N+7 (N+8 when REQ-033 applies).
REQ-025 Back-to-back frames: a grant in the tx_last cycle SHALL start the next frame in the following cycle with no gap; otherwise the FSM SHALL return to IDLE after tx_last.
REQ-026 Requester protocol: a requester SHALL hold req and data stable until its gnt; deasserting req before its grant is legal and SHALL produce no grant and no frame.
REQ-027 gnt_a and gnt_b SHALL never be high in the same cycle.
REQ-028 A 3-bit counter SHALL index the frame bits and SHALL never wrap mid-frame.
REQ-029 In IDLE, tx_valid, tx_first, tx_last and busy SHALL be 0, and tx_bit SHALL be 0.

Reset
REQ-030 While rst_n is low, the block SHALL be forced to IDLE, with all outputs 0, the counter 0, the shift register 0 and last-served = B.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; no residual bits SHALL be sent after release.
REQ-032 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-033 With HAMMING_TX_SECDED_EN defined, each frame SHALL be 8 bits: bit 8 = XOR of code[7:1] (even overall parity), and tx_last SHALL flag bit 8.
REQ-034 Without HAMMING_TX_SECDED_EN, frames SHALL be 7 bits, and no parity logic SHALL be present.

Verification
REQ-035 Single request: req_a=1, data_a=4'b1011 -> gnt_a pulse; tx_bit sequence 1,0,1,0,1,0,1; tx_first on bit 1; tx_last on bit 7; tx_src=0; with the macro, bit 8 = 0.
REQ-036 Tie: req_a=req_b=1 after reset -> A is granted first; B is granted in A's tx_last cycle; B's frame follows with no gap; tx_src=1.
REQ-037 Encoding: data_b=4'b0001 -> bits 1,1,1,0,0,0,0; with the macro, bit 8 = 1; data=4'b0000 -> all bits 0.
REQ-038 Reset mid-frame: rst_n low at bit 4 -> all outputs 0 within the same cycle; after release, no stray tx_valid occurs until a new request.
REQ-039 Withdrawn request: req_b pulses high during a frame and drops before tx_last -> no gnt_b, and the FSM returns to IDLE.
